// File: rtl/uc_pkg.sv
// Shared encodings for the accumulator processor control unit (UC), datapath (UT) and top.
// State encoding includes HOLD, which is only reachable when UC_STEP_EN is defined.
package uc_pkg;

    localparam logic [1:0] OP_NOR = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_STA = 2'b10;
    localparam logic [1:0] OP_JCC = 2'b11;

    localparam logic [2:0] SEL_PASS = 3'b000;
    localparam logic [2:0] SEL_ADD  = 3'b001;
    localparam logic [2:0] SEL_NOR  = 3'b010;

    localparam logic [3:0] ST_RST    = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_OPRD   = 4'd3;
    localparam logic [3:0] ST_LDR1   = 4'd4;
    localparam logic [3:0] ST_EXE    = 4'd5;
    localparam logic [3:0] ST_STORE  = 4'd6;
    localparam logic [3:0] ST_JUMP   = 4'd7;
    localparam logic [3:0] ST_HOLD   = 4'd8;

    typedef enum logic [3:0] {
        S_RST    = ST_RST,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_OPRD   = ST_OPRD,
        S_LDR1   = ST_LDR1,
        S_EXE    = ST_EXE,
        S_STORE  = ST_STORE,
        S_JUMP   = ST_JUMP,
        S_HOLD   = ST_HOLD
    } uc_state_e;

    // ALU operation for the two arithmetic opcodes; anything else is NOR.
    function automatic logic [2:0] exe_sel(input logic [1:0] op);
        return (op == OP_ADD) ? SEL_ADD : SEL_NOR;
    endfunction

endpackage

// File: rtl/uc_pc.sv
// Program counter: reset load, wrapping increment, jump load, frozen while ce=0.
module uc_pc #(
    parameter int ADDR_W   = 6,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              inc,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] RST_VAL = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (ce) begin
            if (jmp) begin
                pc_d = jmp_addr;
            end else if (inc) begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RST_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/uc_ctrl.sv
// Control unit: fetch/decode/sequence FSM driving memory and UT strobes; owns PC and IR.
// Optional single-step mode via macro UC_STEP_EN (adds port step and HOLD state).
module uc_ctrl
    import uc_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              carry,
`ifdef UC_STEP_EN
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [2:0]        sel_UAL,
    output logic              load_R1,
    output logic              load_accu,
    output logic              load_carry,
    output logic              init_carry
);

    uc_state_e         state_q;
    uc_state_e         state_d;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] ir_d;
    logic              pc_inc;
    logic              pc_jmp;
    logic [ADDR_W-1:0] pc;

    logic [1:0]        ir_op;
    logic [ADDR_W-1:0] ir_addr;
    logic [1:0]        rd_op;
    uc_state_e         instr_done;

    assign ir_op   = ir_q[DATA_W-1 -: 2];
    assign ir_addr = ir_q[ADDR_W-1:0];
    assign rd_op   = mem_rdata[DATA_W-1 -: 2];

    // In step mode every instruction (and reset) parks in HOLD until the next step pulse.
`ifdef UC_STEP_EN
    assign instr_done = S_HOLD;
`else
    assign instr_done = S_FETCH;
`endif

    uc_pc #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .inc     (pc_inc),
        .jmp     (pc_jmp),
        .jmp_addr(ir_addr),
        .pc      (pc)
    );

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        pc_inc     = 1'b0;
        pc_jmp     = 1'b0;
        mem_addr   = '0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        sel_UAL    = SEL_PASS;
        load_R1    = 1'b0;
        load_accu  = 1'b0;
        load_carry = 1'b0;
        init_carry = 1'b0;

        if (ce) begin
            case (state_q)
                S_RST: state_d = instr_done;
`ifdef UC_STEP_EN
                S_HOLD: begin
                    if (step) begin
                        state_d = S_FETCH;
                    end
                end
`endif
                S_FETCH: begin
                    mem_addr = pc;
                    mem_en   = 1'b1;
                    state_d  = S_DECODE;
                end
                // IR is not loaded yet, so branch on the word arriving from memory.
                S_DECODE: begin
                    ir_d   = mem_rdata;
                    pc_inc = 1'b1;
                    case (rd_op)
                        OP_STA:  state_d = S_STORE;
                        OP_JCC:  state_d = S_JUMP;
                        default: state_d = S_OPRD;
                    endcase
                end
                S_OPRD: begin
                    mem_addr = ir_addr;
                    mem_en   = 1'b1;
                    state_d  = S_LDR1;
                end
                S_LDR1: begin
                    load_R1 = 1'b1;
                    state_d = S_EXE;
                end
                S_EXE: begin
                    sel_UAL    = exe_sel(ir_op);
                    load_accu  = 1'b1;
                    load_carry = (ir_op == OP_ADD);
                    state_d    = instr_done;
                end
                S_STORE: begin
                    mem_addr = ir_addr;
                    mem_en   = 1'b1;
                    mem_we   = 1'b1;
                    state_d  = instr_done;
                end
                // Branch is taken on carry clear; carry is cleared either way.
                S_JUMP: begin
                    pc_jmp     = ~carry;
                    load_carry = 1'b1;
                    init_carry = 1'b1;
                    state_d    = instr_done;
                end
                default: state_d = S_RST;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RST;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_uc_ctrl.sv
// Self-checking bench for uc_ctrl: instruction-level reference model plus synchronous memory.
// Build with UC_STEP_EN defined to exercise single-step mode.
module tb_uc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic [7:0] mem_rdata;
    logic       carry;
    logic       step;
    logic [5:0] mem_addr;
    logic       mem_en;
    logic       mem_we;
    logic [2:0] sel_UAL;
    logic       load_R1;
    logic       load_accu;
    logic       load_carry;
    logic       init_carry;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [64];
    logic [5:0] pc_m;

    localparam logic [14:0] IDLE = 15'h0;

    uc_ctrl #(
        .ADDR_W  (6),
        .DATA_W  (8),
        .RESET_PC(0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .mem_rdata (mem_rdata),
        .carry     (carry),
`ifdef UC_STEP_EN
        .step      (step),
`endif
        .mem_addr  (mem_addr),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .sel_UAL   (sel_UAL),
        .load_R1   (load_R1),
        .load_accu (load_accu),
        .load_carry(load_carry),
        .init_carry(init_carry)
    );

    always #5 clk = ~clk;

    // Packed expected output vector: {en, we, addr, sel, R1, accu, lcarry, icarry}.
    function automatic logic [14:0] mk(input logic en, input logic we, input logic [5:0] a,
                                       input logic [2:0] sel, input logic r1, input logic acc,
                                       input logic lc, input logic ic);
        return {en, we, a, sel, r1, acc, lc, ic};
    endfunction

    task automatic chk(input string tag, input logic [14:0] exp);
        logic [14:0] obs;
        obs = {mem_en, mem_we, mem_addr, sel_UAL, load_R1, load_accu, load_carry, init_carry};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; memory returns the addressed word the cycle after a read, garbage otherwise.
    task automatic clk_cycle();
        logic       en, we, c;
        logic [5:0] a;
        en = mem_en;
        we = mem_we;
        a  = mem_addr;
        c  = ce;
        @(posedge clk);
        #1;
        if (c) begin
            if (en && !we) mem_rdata = mem[a];
            else           mem_rdata = 8'($urandom);
        end
        @(negedge clk);
    endtask

    task automatic step_chk(input string tag, input logic [14:0] exp, input logic pause);
        chk(tag, exp);
        if (pause) begin
            ce = 1'b0;
            #1 chk({tag, "_ce0"}, IDLE);
            repeat (3) begin
                clk_cycle();
                chk({tag, "_frozen"}, IDLE);
            end
            ce = 1'b1;
            #1 chk({tag, "_resume"}, exp);
        end
        clk_cycle();
    endtask

    task automatic enter_fetch(input int n_wait);
`ifdef UC_STEP_EN
        step = 1'b0;
        repeat (n_wait) begin
            chk("hold_wait", IDLE);
            clk_cycle();
        end
        chk("hold", IDLE);
        step = 1'b1;
        #1 chk("hold_step", IDLE);
        clk_cycle();
        step = 1'b0;
`else
        if (n_wait < 0) step = 1'b0;
`endif
    endtask

    // Executes one instruction word at pc_m; pause_at selects a cycle (1..n) for a ce=0 stall.
    task automatic run_instr(input logic [7:0] w, input logic c, input int pause_at);
        logic [1:0] op;
        logic [5:0] a;
        op = w[7:6];
        a  = w[5:0];
        enter_fetch(2);
        mem[pc_m] = w;
        carry = c;
        step_chk("fetch", mk(1, 0, pc_m, 3'b000, 0, 0, 0, 0), pause_at == 1);
        step_chk("decode", IDLE, pause_at == 2);
        case (op)
            2'b00, 2'b01: begin
                step_chk("oprd", mk(1, 0, a, 3'b000, 0, 0, 0, 0), pause_at == 3);
                step_chk("ldr1", mk(0, 0, 6'h0, 3'b000, 1, 0, 0, 0), pause_at == 4);
                if (op == 2'b01) step_chk("exe_add", mk(0, 0, 6'h0, 3'b001, 0, 1, 1, 0), pause_at == 5);
                else             step_chk("exe_nor", mk(0, 0, 6'h0, 3'b010, 0, 1, 0, 0), pause_at == 5);
                pc_m = pc_m + 6'd1;
            end
            2'b10: begin
                step_chk("store", mk(1, 1, a, 3'b000, 0, 0, 0, 0), pause_at == 3);
                pc_m = pc_m + 6'd1;
            end
            default: begin
                step_chk("jump", mk(0, 0, 6'h0, 3'b000, 0, 0, 1, 1), pause_at == 3);
                pc_m = c ? pc_m + 6'd1 : a;
            end
        endcase
    endtask

    initial begin
        logic [7:0] w;
        int         p;

        rst       = 1'b1;
        ce        = 1'b1;
        carry     = 1'b0;
        step      = 1'b0;
        mem_rdata = 8'h00;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        pc_m = 6'h00;

        @(negedge clk);
        chk("reset", IDLE);
        @(negedge clk);
        chk("reset_held", IDLE);
        rst = 1'b0;
        #1 chk("rst_state", IDLE);
        clk_cycle();

`ifdef UC_STEP_EN
        enter_fetch(10);
        enter_fetch(0);
`endif

        // Directed: NOR, ADD, STA, JCC taken/not taken, jump to top, wrap, stall mid-EXE.
        run_instr(8'h00, 1'b0, 0);
        mem[6'h10] = 8'h5A;
        run_instr({2'b01, 6'h10}, 1'b0, 0);
        run_instr({2'b10, 6'h3F}, 1'b1, 0);
        run_instr({2'b11, 6'h05}, 1'b0, 0);
        run_instr({2'b11, 6'h20}, 1'b1, 0);
        run_instr({2'b11, 6'h3F}, 1'b0, 0);
        run_instr({2'b01, 6'h11}, 1'b1, 5);
        run_instr({2'b11, pc_m}, 1'b0, 0);
        run_instr({2'b00, 6'h2A}, 1'b0, 3);

        // Asynchronous reset during the operand fetch of an ADD.
        enter_fetch(1);
        mem[pc_m] = {2'b01, 6'h33};
        chk("rst_mid_fetch", mk(1, 0, pc_m, 3'b000, 0, 0, 0, 0));
        clk_cycle();
        clk_cycle();
        chk("rst_mid_oprd", mk(1, 0, 6'h33, 3'b000, 0, 0, 0, 0));
        rst = 1'b1;
        #1 chk("rst_mid_async", IDLE);
        clk_cycle();
        chk("rst_mid_held", IDLE);
        rst = 1'b0;
        #1 chk("rst_mid_state", IDLE);
        clk_cycle();
        pc_m = 6'h00;

        for (int n = 0; n < 150; n++) begin
            w = 8'($urandom);
            mem[w[5:0]] = 8'($urandom);
            p = ($urandom_range(7) == 0) ? int'($urandom_range(5, 1)) : 0;
            run_instr(w, 1'($urandom), p);
        end
        enter_fetch(1);
        chk("final_fetch", mk(1, 0, pc_m, 3'b000, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
